// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC controller: the FSM state encoding
// and the instruction constants.
package fetch_pkg;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 3'd0;
  localparam fetch_state_t ST_REQ   = 3'd1;
  localparam fetch_state_t ST_WAIT  = 3'd2;
  localparam fetch_state_t ST_HOLD  = 3'd3;
  localparam fetch_state_t ST_DRAIN = 3'd4;
  localparam fetch_state_t ST_HALT  = 3'd5;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] INSTR_STEP = 32'd4;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-fetch-address selection. A redirect overrides any prediction, and
// mret/ecall/ebreak stop fetching until a redirect arrives.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] fet_pc,
  input  logic        isjal,
  input  logic        isjalr,
  input  logic        isbxx,
  input  logic        predict_bxxtaken,
  input  logic        ismret,
  input  logic        isecallbk,
  input  logic [31:0] jaloffset,
  input  logic [31:0] bxxoffset,
  input  logic [31:0] jalroffset,
  input  logic [31:0] jalr_xn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        halt
);

  always_comb begin
    next_pc = fet_pc + INSTR_STEP;
    halt    = 1'b0;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (ismret | isecallbk) begin
      next_pc = fet_pc;
      halt    = 1'b1;
    end else if (isjal) begin
      next_pc = fet_pc + jaloffset;
    end else if (isbxx & predict_bxxtaken) begin
      next_pc = fet_pc + bxxoffset;
    end else if (isjalr) begin
      next_pc = (jalr_xn + jalroffset) & ~32'h1;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage controller: one outstanding imem request at a time, an instruction
// register handed to decode, and next-PC steering from predictions and redirects.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] fet_instr,
  output logic [31:0] fet_pc,
  output logic        fet_valid,
  input  logic        dec_ready,
  input  logic        isjal,
  input  logic        isjalr,
  input  logic        isbxx,
  input  logic        predict_bxxtaken,
  input  logic        ismret,
  input  logic        isecallbk,
  input  logic [31:0] jaloffset,
  input  logic [31:0] bxxoffset,
  input  logic [31:0] jalroffset,
  input  logic [31:0] jalr_xn,
  input  logic        jalr_dep,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  fet_pc_q, fet_pc_d;
  logic         ir_valid_q, ir_valid_d;

  logic [31:0]  next_pc;
  logic         halt;
  logic         handoff;

  fetch_next_pc u_next_pc (
    .fet_pc           (fet_pc_q),
    .isjal            (isjal),
    .isjalr           (isjalr),
    .isbxx            (isbxx),
    .predict_bxxtaken (predict_bxxtaken),
    .ismret           (ismret),
    .isecallbk        (isecallbk),
    .jaloffset        (jaloffset),
    .bxxoffset        (bxxoffset),
    .jalroffset       (jalroffset),
    .jalr_xn          (jalr_xn),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .next_pc          (next_pc),
    .halt             (halt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      fet_pc_q   <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      fet_pc_q   <= fet_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    fet_pc_d   = fet_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (imem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rsp_valid && !redirect_valid) begin
          ir_d       = imem_rsp_data;
          fet_pc_d   = pc_q;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          ir_valid_d = 1'b0;
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_DRAIN: if (imem_rsp_valid) state_d = ST_REQ;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    // A response landing in the same cycle as the redirect already retires the
    // outstanding request, so there is nothing left to drain.
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      case (state_q)
        ST_WAIT, ST_DRAIN: state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_REQ:            state_d = imem_req_ready ? ST_DRAIN : ST_REQ;
        default:           state_d = ST_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == ST_REQ);
    imem_req_addr  = pc_q;
    fet_valid      = (state_q == ST_HOLD) & ir_valid_q & ~jalr_dep;
    fet_instr      = ir_q;
    fet_pc         = fet_pc_q;
    handoff        = fet_valid & dec_ready;
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: linear stimulus, immediate-assertion checks.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] fet_instr;
  logic [31:0] fet_pc;
  logic        fet_valid;
  logic        dec_ready;
  logic        isjal, isjalr, isbxx, predict_bxxtaken, ismret, isecallbk;
  logic [31:0] jaloffset, bxxoffset, jalroffset, jalr_xn;
  logic        jalr_dep;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .fet_instr        (fet_instr),
    .fet_pc           (fet_pc),
    .fet_valid        (fet_valid),
    .dec_ready        (dec_ready),
    .isjal            (isjal),
    .isjalr           (isjalr),
    .isbxx            (isbxx),
    .predict_bxxtaken (predict_bxxtaken),
    .ismret           (ismret),
    .isecallbk        (isecallbk),
    .jaloffset        (jaloffset),
    .bxxoffset        (bxxoffset),
    .jalroffset       (jalroffset),
    .jalr_xn          (jalr_xn),
    .jalr_dep         (jalr_dep),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_flags();
    isjal = 0; isjalr = 0; isbxx = 0; predict_bxxtaken = 0; ismret = 0; isecallbk = 0;
    jaloffset = 0; bxxoffset = 0; jalroffset = 0; jalr_xn = 0; jalr_dep = 0;
    dec_ready = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  // From REQ: accept the request, return one word, land in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    imem_rsp_valid = 1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 0;
  endtask

  // From REQ with ready low: steer the pending address.
  task automatic steer(input logic [31:0] target);
    redirect_valid = 1;
    redirect_pc    = target;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    reset = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    clear_flags();
    tick(); tick();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_fet_valid", {31'b0, fet_valid}, 32'd0);
    check("rst_fet_instr", fet_instr, 32'h0000_0013);
    check("rst_fet_pc", fet_pc, 32'h0);

    // First fetch after reset
    reset = 0; imem_req_ready = 1;
    tick();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    tick();
    imem_req_ready = 0;
    check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 0;
    check("hold_fet_valid", {31'b0, fet_valid}, 32'd1);
    check("hold_fet_instr", fet_instr, 32'h0000_0013);
    dec_ready = 1;
    tick();
    dec_ready = 0;
    check("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("seq_req_addr", imem_req_addr, 32'h4);

    // jal at 0x100
    steer(32'h100);
    check("steer_req_addr", imem_req_addr, 32'h100);
    do_fetch(32'h0080_00EF);
    check("jal_fet_pc", fet_pc, 32'h100);
    isjal = 1; jaloffset = 32'h8; dec_ready = 1;
    tick();
    clear_flags();
    check("jal_req_addr", imem_req_addr, 32'h108);

    // Predicted-taken backward branch at 0x200
    steer(32'h200);
    do_fetch(32'hFE00_0EE3);
    isbxx = 1; predict_bxxtaken = 1; bxxoffset = 32'hFFFF_FFFC; dec_ready = 1;
    tick();
    clear_flags();
    check("bxx_taken_addr", imem_req_addr, 32'h1FC);

    // Not-taken prediction falls through
    do_fetch(32'hFE00_0EE3);
    isbxx = 1; predict_bxxtaken = 0; bxxoffset = 32'hFFFF_FFFC; dec_ready = 1;
    tick();
    clear_flags();
    check("bxx_nt_addr", imem_req_addr, 32'h200);

    // jalr held by a dependency for two cycles
    do_fetch(32'h0000_80E7);
    isjalr = 1; jalr_xn = 32'h1001; jalroffset = 32'h10; jalr_dep = 1; dec_ready = 1;
    #1;
    check("jalr_dep_c1", {31'b0, fet_valid}, 32'd0);
    tick();
    check("jalr_dep_c2", {31'b0, fet_valid}, 32'd0);
    check("jalr_dep_noreq", {31'b0, imem_req_valid}, 32'd0);
    tick();
    jalr_dep = 0;
    #1;
    check("jalr_release", {31'b0, fet_valid}, 32'd1);
    tick();
    clear_flags();
    check("jalr_req_addr", imem_req_addr, 32'h1010);

    // Redirect while waiting: the stale response is dropped
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 0;
    check("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0;
    check("drain_fet_valid", {31'b0, fet_valid}, 32'd0);
    check("drain_ir_kept", fet_instr, 32'h0000_80E7);
    check("drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("drain_req_addr", imem_req_addr, 32'h400);

    // ecall halts fetch until a redirect
    do_fetch(32'h0000_0073);
    check("ecall_fet_pc", fet_pc, 32'h400);
    isecallbk = 1; dec_ready = 1;
    tick();
    clear_flags();
    check("halt_noreq0", {31'b0, imem_req_valid}, 32'd0);
    tick(); tick();
    check("halt_noreq2", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 0;
    check("halt_exit_valid", {31'b0, imem_req_valid}, 32'd1);
    check("halt_exit_addr", imem_req_addr, 32'h80);

    // Handoff and redirect together: the redirect beats the jal prediction
    do_fetch(32'h0080_00EF);
    isjal = 1; jaloffset = 32'h8; dec_ready = 1;
    redirect_valid = 1; redirect_pc = 32'h300;
    tick();
    clear_flags();
    check("ho_redir_valid", {31'b0, fet_valid}, 32'd0);
    check("ho_redir_addr", imem_req_addr, 32'h300);

    // Reset mid-operation
    do_fetch(32'h1234_5678);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    check("mid_rst_instr", fet_instr, 32'h0000_0013);
    check("mid_rst_fet_pc", fet_pc, 32'h0);
    tick();
    check("mid_rst_addr", imem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage PC generator and instruction-memory request controller.
- Issues one instruction fetch at a time and holds the returned word in an instruction register (IR).
- Drives the IR to the fetch mini-decoder and uses its early jal/branch/jalr predictions to pick the next fetch address.
- Hands the instruction to the decode stage, and accepts redirects from execute (mispredict) and CSR (trap/mret).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction
fet_instr  out  32  IR contents; feeds mini-decoder rv32_instr and decode stage
fet_pc  out  32  PC of IR
fet_valid  out  1  IR valid to decode
dec_ready  in  1  decode accepts IR this cycle
isjal, isjalr, isbxx, predict_bxxtaken, ismret, isecallbk  in  1  mini-decoder flags for IR
jaloffset, bxxoffset, jalroffset, jalr_xn  in  32  mini-decoder offsets and jalr base
jalr_dep  in  1  jalr base not yet available
redirect_valid  in  1  execute/CSR redirect
redirect_pc  in  32  redirect target

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, ir_valid=0.
  - imem_req_valid=0, fet_valid=0, fet_instr=32'h0000_0013 (nop), fet_pc=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT.
- IDLE: one cycle after reset deasserts, go to REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT.
  - Address may change before acceptance, but only by redirect.
- WAIT:
  - On imem_rsp_valid: IR <= rsp_data, fet_pc <= pc, ir_valid=1, go to HOLD.
  - The response may arrive at the earliest one cycle after acceptance.
- HOLD: fet_valid = ir_valid & ~jalr_dep.
- Handoff = fet_valid & dec_ready. On handoff, next pc is chosen in this priority order (all additions modulo 2^32):
  1. ismret | isecallbk: go to HALT and issue no request.
  2. isjal: fet_pc + jaloffset.
  3. isbxx & predict_bxxtaken: fet_pc + bxxoffset.
  4. isjalr: (jalr_xn + jalroffset) & ~32'h1.
  5. Otherwise: fet_pc + 4.
  - Then ir_valid=0 and go to REQ. imem_req_valid asserts the cycle after handoff.
- jalr_dep:
  - While set, the jalr stays in IR and fet_valid=0.
  - Handoff occurs the first cycle jalr_dep=0 and dec_ready=1.
- HALT: wait for redirect_valid; imem_req_valid=0 throughout.
- Redirect (redirect_valid, highest priority, any state):
  - pc <= redirect_pc, ir_valid <= 0, fet_valid=0 next cycle.
  - From WAIT, or from REQ with imem_req_ready=1 in the same cycle: go to DRAIN.
  - All other states: go to REQ.
  - A handoff and a redirect in the same cycle: the handoff completes (decode has taken the instruction), the redirect wins next pc, and prediction is ignored.
- DRAIN:
  - Discard the next imem_rsp_valid, then go to REQ.
  - A redirect while in DRAIN updates pc and stays in DRAIN.
- At most one outstanding request at all times; imem_req_valid is never asserted in WAIT, DRAIN, HOLD or HALT.
- Redirect targets have bit 0 already cleared by the producer. No misalignment trap is raised here.
- Reset during any state returns to IDLE next cycle. A pending response after reset is ignored, because IDLE/REQ do not sample rsp.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (3-bit localparams for the six states);
  - NOP_INSTR=32'h0000_0013;
  - INSTR_STEP=4.
- Opcode constants stay in the existing opcode define file.
- One combinational sub-module, fetch_next_pc: takes the flags, offsets, fet_pc and redirect inputs and returns next_pc and a halt flag.
- The FSM and registers live in fetch_pc_ctrl.

Test Plan:
- Reset, then release with imem_req_ready=1 -> first imem_req_addr=0x0000_0000 one cycle after release. Response 0x00000013 with dec_ready=1 -> next request addr 0x4.
- IR=0x008000EF (jal x1,8) at pc 0x100 -> next imem_req_addr=0x108.
- IR=0xFE000EE3 (beq x0,x0,-4) at pc 0x200 -> predict_bxxtaken=1 -> next addr 0x1FC.
- IR=jalr with jalr_dep=1 for 2 cycles, jalr_xn=0x1001, jalroffset=0x10 -> fet_valid=0 for 2 cycles, then handoff -> next addr 0x1010.
- Redirect to 0x400 while in WAIT -> the following response (any data) is dropped with fet_valid staying 0, and the next request addr is 0x400.
- IR=0x00000073 (ecall) handed off -> no request until redirect_valid with redirect_pc=0x80 -> request addr 0x80 next cycle.
